// File: rtl/rv32_pkg.sv
// Shared RV32 types for the multiply/divide unit: operation encoding (equal to funct3),
// control states and operand-signedness predicates.
package rv32_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_div_op(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic is_rem_op(input md_op_e op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    // MUL is treated as signed; its low half is identical either way.
    function automatic logic is_signed_a(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    // A borrow out of the top bit means the divisor did not fit: restore.
    assign next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit (shift-add multiply, restoring divide) with kill.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a combinational product.
module muldiv_unit
    import rv32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  md_op_e           operator_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          state_q, state_d;
    md_op_e             op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, rem_q, quo_q, dvsr_q, result_q;
    logic               neg_q;

    logic               sign_a, sign_b, div_zero, div_ovf, direct_done, accept, last_iter;
    logic [WIDTH-1:0]   mag_a, mag_b, direct_res, step_rem, step_quo;
    logic [WIDTH-1:0]   div_raw, div_res, mul_res, final_res;

    // Handshakes: a request transfers on a rising edge with valid_i && ready_o (unless
    // kill_i); a result transfers on a rising edge with valid_o && ready_i. Only one
    // operation is ever in flight, so ready_o is high exactly in IDLE.
    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign result_o = result_q;

    assign sign_a   = is_signed_a(operator_i) & operand_a_i[WIDTH-1];
    assign sign_b   = is_signed_b(operator_i) & operand_b_i[WIDTH-1];
    assign mag_a    = sign_a ? -operand_a_i : operand_a_i;
    assign mag_b    = sign_b ? -operand_b_i : operand_b_i;
    assign div_zero = is_div_op(operator_i) && (operand_b_i == '0);
    assign div_ovf  = (operator_i == MD_DIV || operator_i == MD_REM)
                      && (operand_a_i == MIN_NEG) && (operand_b_i == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     fast_a, fast_b;
    logic signed [2*WIDTH+1:0] fast_prod;
    assign fast_a    = {sign_a, operand_a_i};
    assign fast_b    = {sign_b, operand_b_i};
    assign fast_prod = fast_a * fast_b;
`endif

    // Results that are known at accept time bypass BUSY entirely.
    always_comb begin
        direct_done = div_zero | div_ovf;
        direct_res  = '0;
        if (div_zero) begin
            direct_res = is_rem_op(operator_i) ? operand_a_i : '1;
        end else if (div_ovf) begin
            direct_res = is_rem_op(operator_i) ? '0 : operand_a_i;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div_op(operator_i)) begin
            direct_done = 1'b1;
            direct_res  = (operator_i == MD_MUL) ? fast_prod[WIDTH-1:0]
                                                 : fast_prod[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            MD_IDLE: if (valid_i) begin
                accept  = 1'b1;
                state_d = direct_done ? MD_DONE : MD_BUSY;
            end
            MD_BUSY: if (cnt_q == LAST_CNT) state_d = MD_DONE;
            MD_DONE: if (ready_i) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (kill_i) begin
            state_d = MD_IDLE;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    // Signed multiplier bit of weight -2^(WIDTH-1) is handled by subtracting on the last step.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            if (cnt_q == LAST_CNT && is_signed_b(op_q)) acc_d = acc_q - mcand_q;
            else                                        acc_d = acc_q + mcand_q;
        end
    end

    assign last_iter = (state_q == MD_BUSY) && (cnt_q == LAST_CNT);
    assign mul_res   = (op_q == MD_MUL) ? acc_d[WIDTH-1:0] : acc_d[2*WIDTH-1:WIDTH];
    assign div_raw   = is_rem_op(op_q) ? step_rem : step_quo;
    assign div_res   = neg_q ? -div_raw : div_raw;
    assign final_res = is_div_op(op_q) ? div_res : mul_res;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= operator_i;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{sign_a}}, operand_a_i};
            mplier_q <= operand_b_i;
            rem_q    <= '0;
            quo_q    <= mag_a;
            dvsr_q   <= mag_b;
            neg_q    <= is_div_op(operator_i)
                        && (is_rem_op(operator_i) ? sign_a : (sign_a ^ sign_b));
            if (direct_done) result_q <= direct_res;
        end else if (state_q == MD_BUSY && !kill_i) begin
            cnt_q    <= cnt_q + 1'b1;
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= step_rem;
            quo_q    <= step_quo;
            if (last_iter) result_q <= final_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of ops with expected results and latencies,
// plus hand-written backpressure, kill and async-reset sequences.
module tb_muldiv_unit;
    import rv32_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif
    localparam int DL = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    md_op_e      operator_i = MD_MUL;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vq[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .operator_i  (operator_i),
        .kill_i      (kill_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vq.push_back(v);
    endtask

    // Issue a request at a negedge, then wait for valid_o and count cycles from the accept edge.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("ready_before_issue", 64'(ready_o), 64'd1);
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        valid_i     = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        issue(op, a, b);
        lat = 1;
        @(negedge clk);
        while (!valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: valid_o never rose within %0d cycles", name, lat);
            return;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, 64'(result_o), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold"}, {31'd0, valid_o, ready_o, result_o}, {31'd0, 1'b1, 1'b0, exp});
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({name, "_after_ack"}, {62'd0, ready_o, valid_o}, {62'd0, 1'b1, 1'b0});
    endtask

    initial begin
        bit seen;

        add_vec(MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML);
        add_vec(MD_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, ML);
        add_vec(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, ML);
        add_vec(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML);
        add_vec(MD_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, ML);
        add_vec(MD_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, ML);
        add_vec(MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DL);
        add_vec(MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DL);
        add_vec(MD_DIVU,   32'd100,       32'd7,         32'd14,        DL);
        add_vec(MD_REMU,   32'd100,       32'd7,         32'd2,         DL);
        add_vec(MD_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DL);
        add_vec(MD_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DL);
        add_vec(MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DL);
        add_vec(MD_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DL);
        add_vec(MD_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1);
        add_vec(MD_REM,    32'h0000_1234, 32'd0,         32'h0000_1234, 1);
        add_vec(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        add_vec(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        repeat (3) @(negedge clk);
        check("reset_outputs", {30'd0, ready_o, valid_o, result_o}, {30'd0, 1'b1, 1'b0, 32'd0});
        rst = 1'b0;

        foreach (vq[i]) begin
            run_op($sformatf("vec%0d_%s", i, vq[i].op.name()), vq[i].op, vq[i].a, vq[i].b,
                   vq[i].exp, vq[i].lat, 0);
        end

        // Backpressure: hold the result for 10 cycles, then a follow-up request.
        run_op("bp_divu", MD_DIVU, 32'd100, 32'd7, 32'd14, DL, 10);
        run_op("bp_next_mul", MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML, 0);

        // Kill in the fifth BUSY cycle of a DIVU.
        issue(MD_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk);
        #1 kill_i = 1'b0;
        @(negedge clk);
        check("kill_busy_idle", {62'd0, ready_o, valid_o}, {62'd0, 1'b1, 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("kill_busy_no_valid", 64'(seen), 64'd0);
        run_op("post_kill_mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML, 0);

        // Kill concurrent with a request in IDLE drops it.
        @(negedge clk);
        operator_i  = MD_DIVU;
        operand_a_i = 32'h0000_1234;
        operand_b_i = 32'd0;
        valid_i     = 1'b1;
        kill_i      = 1'b1;
        @(posedge clk);
        #1 begin valid_i = 1'b0; kill_i = 1'b0; end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o || !ready_o) seen = 1'b1;
        end
        check("kill_idle_dropped", 64'(seen), 64'd0);

        // Asynchronous reset between clock edges while BUSY.
        issue(MD_DIV, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {30'd0, ready_o, valid_o, result_o}, {30'd0, 1'b1, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        run_op("after_reset_div", MD_DIV, 32'd20, 32'd3, 32'd6, DL, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time over a valid/ready handshake and iterates internally (shift-add multiply, restoring divide).
- Returns the result over a second valid/ready handshake.
- Supports pipeline flush through a kill input.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- operand_a_i  input  WIDTH  rs1 value.
- operand_b_i  input  WIDTH  rs2 value.
- operator_i  input  md_op_e  operation select.
- kill_i  input  1  abort the in-flight operation.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH  result.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, ready_o=1, valid_o=0, result_o=0, counter=0, all datapath registers 0.
- States:
  - IDLE: ready_o=1. valid_i=1 captures operands and op → BUSY, or → DONE for a special case.
  - BUSY: ready_o=0, valid_o=0. One iteration per cycle. When counter reaches WIDTH-1 → DONE.
  - DONE: valid_o=1, result_o stable. ready_i=1 → IDLE.
- Latency:
  - Normal ops: valid_o rises exactly WIDTH+1 cycles after the accept edge.
  - Divide by zero and signed overflow: valid_o is asserted 1 cycle after accept (IDLE→DONE).
- Back-to-back: ready_o is high only in IDLE. A new request is accepted earliest the cycle after the DONE handshake. No overlap.
- Multiply:
  - Operands are sign- or zero-extended to 2·WIDTH according to the op (MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned).
  - Full 2·WIDTH product is computed.
  - MUL returns the low WIDTH bits; the other ops return the high WIDTH bits.
- Divide:
  - Signed ops take magnitudes first and fix the signs at the end.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Boundary cases:
  - b=0: DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow (a = most-negative, b = -1): DIV returns a; REM returns 0.
  - WIDTH-bit wrap-around on all results; no exceptions, no flags.
- kill_i:
  - Priority over everything except reset, in any state.
  - Next state = IDLE; valid_o deasserted next cycle; no result is ever presented.
  - kill_i concurrent with valid_i in IDLE: the request is dropped.
- DONE with ready_i=0: hold result_o and valid_o indefinitely.
- Async reset mid-operation: immediate return to the reset values above.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - Multiply ops use a combinational WIDTH×WIDTH (2·WIDTH+2 signed) product registered in one cycle: accept → DONE, valid_o 1 cycle after accept.
  - Divide is unchanged.
- Undefined: multiply is iterative shift-add, WIDTH+1 cycle latency, no hardware multiplier inferred.

Decomposition:
- rv32_pkg additions:
  - md_op_e enum (MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU), 3-bit, encoding equal to funct3.
  - md_state_e (MD_IDLE, MD_BUSY, MD_DONE).
  - Helper predicates is_div_op, is_signed_a, is_signed_b.
- One sub-module: muldiv_div_step, a combinational single restoring-division iteration (remainder/quotient in, shifted remainder/quotient out), reused by the BUSY datapath.
- The control FSM and the multiplier stay in muldiv_unit.

Test Plan:
- MUL a=0x0000_0007, b=0xFFFF_FFFD (WIDTH=32): result_o=0xFFFF_FFEB; MULH same operands: 0xFFFF_FFFF. valid_o exactly 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
- DIV a=-7 (0xFFFF_FFF9), b=2: result 0xFFFF_FFFD. REM same operands: 0xFFFF_FFFF. DIVU a=100, b=7: 14. REMU a=100, b=7: 2.
- DIVU a=0x1234, b=0: 0xFFFF_FFFF. REM a=0x1234, b=0: 0x1234. DIV a=0x8000_0000, b=0xFFFF_FFFF: 0x8000_0000. REM same operands: 0. Each of these: valid_o 1 cycle after accept.
- Backpressure: hold ready_i=0 for 10 cycles in DONE → result_o and valid_o stable, ready_o=0. Then ready_i=1 → ready_o=1 next cycle. A second request issued then completes correctly.
- Assert kill_i at BUSY cycle 5 of a DIVU → ready_o=1 next cycle, valid_o never rises. The following MULHU 0xFFFF_FFFF×0xFFFF_FFFF returns 0xFFFF_FFFE.
- Assert rst_i asynchronously mid-BUSY (between clock edges) → valid_o=0, ready_o=1, result_o=0 immediately. Release reset and run DIV 20/3 → 6.
